accel_seq_ctrl: RTL and testbench
=================================

Name: accel_seq_ctrl

Overview:
- Inference sequencer between the AHB subordinate's register/push outputs and the compute datapath (weight FIFO, input FIFO, systolic array, bias/activation stage).
- Tracks weight-FIFO occupancy from weight pushes.
- On a start request, runs one batch in order: weight load, input stream, array drain, bias/activation, output hand-off.
- Reports progress and sticky errors back through status_reg/err_reg.

Parameters:
- ARRAY_DIM, 8: array rows/cols; weight rows per load and input vectors per batch.
- WFIFO_DEPTH, 16: weight FIFO depth; occupancy saturation limit.
- DRAIN_CYCLES, 14: cycles array_en is held after the last input pop.
- TIMEOUT, 255: maximum consecutive input-starved cycles in STREAM.

Ports:
- clk  in  1  system clock
- n_rst  in  1  reset
- ctrl_reg  in  8  bit0 start (rising edge), bit1 clear_err (level), others ignored
- wr_en_push  in  1  one-cycle push strobe from AHB subordinate
- is_weight  in  1  qualifies wr_en_push as a weight push (else input push)
- handshake  in  1  host has consumed output_data
- ififo_empty  in  1  input FIFO empty
- wfifo_pop  out  1  pop one weight row
- w_load  out  1  shift the popped row into the array
- ififo_pop  out  1  pop one input vector
- array_en  out  1  advance array one step
- bias_act_en  out  1  apply bias and act_mode
- out_valid  out  1  output_data valid for host
- status_reg  out  8  status to AHB subordinate
- err_reg  out  16  sticky errors

Behaviour:
- Reset: one clk, synchronous, active-low, n_rst.
- Reset effects: state IDLE; occupancy, beat, stall and drain counters 0; all outputs 0; err_reg 0; done 0. Reset mid-batch aborts immediately with no completion.
- Start edge: start_edge = ctrl_reg[0] & ~prev, where prev is registered (reset 0).
- Weight occupancy w_cnt:
  - +1 on (wr_en_push & is_weight); −1 on wfifo_pop; both in the same cycle leaves it unchanged.
  - Push at WFIFO_DEPTH with no pop: stays saturated and sets err[3].
- All datapath outputs are a decode of registered state/counters (Moore).
- IDLE:
  - start_edge with w_cnt ≥ ARRAY_DIM: go to LOAD_W, clear done.
  - start_edge otherwise: set err[0], stay in IDLE.
- LOAD_W: wfifo_pop = w_load = 1 for exactly ARRAY_DIM cycles, then go to STREAM.
- STREAM:
  - ififo_pop = array_en = ~ififo_empty.
  - Beat counter increments per pop; after ARRAY_DIM pops go to DRAIN.
  - Empty cycles increment the stall counter; a pop clears it.
  - Stall counter reaching TIMEOUT: set err[4], go to IDLE, done stays 0.
- DRAIN: array_en = 1, ififo_pop = 0, for DRAIN_CYCLES cycles, then go to ACT.
- ACT: bias_act_en = 1 for one cycle, then go to OUT.
- OUT: out_valid = 1 until handshake is sampled high; then go to IDLE and set done.
- Any state other than IDLE:
  - start_edge sets err[1] and is otherwise ignored.
  - Weight push during LOAD_W/STREAM sets err[2]; it is still counted.
- Latency, no stalls, defaults: start edge at cycle 0 → w_load cycles 1–8, ififo_pop 9–16, drain 17–30, bias_act_en 31, out_valid from 32.
- err_reg:
  - Bits 4:0 are sticky; 15:5 are always 0.
  - ctrl_reg[1] high clears err_reg; an error raised in the same cycle wins (bit is set).
- status_reg:
  - bit0 busy (state ≠ IDLE)
  - bit1 done (sticky until next accepted start)
  - bit2 weights_ready (w_cnt ≥ ARRAY_DIM)
  - bit3 out_valid
  - bit4 |err_reg
  - 7:5 always 0

Decomposition:
- Package accel_ctrl_pkg:
  - state enum (IDLE, LOAD_W, STREAM, DRAIN, ACT, OUT)
  - ERR_* bit indices 0–4
  - STS_* bit indices 0–4
  - CTRL_START/CTRL_CLR_ERR bit indices
- Sub-module wfifo_occ_counter: parameterized up/down saturating counter with overflow flag, used for w_cnt.
- FSM, beat/stall/drain counters and register outputs stay in accel_seq_ctrl.

Test Plan:
- 8 weight pushes, start, ififo_empty = 0 → w_load cycles 1–8, ififo_pop 9–16, array_en 9–30, bias_act_en 31, out_valid 32. Handshake at 35 → status_reg = 0x02 at 36, w_cnt = 0.
- Start with 5 weights → stays IDLE, err_reg = 0x0001, status_reg = 0x10. clear_err high one cycle → err_reg = 0x0000.
- ififo_empty high for 3 cycles mid-STREAM → ififo_pop/array_en low those cycles, exactly 8 pops total, ACT delayed by 3 cycles.
- TIMEOUT = 4, ififo_empty stuck high in STREAM → IDLE after 4 stall cycles, err_reg = 0x0010, done = 0.
- 17 weight pushes from empty → w_cnt saturates at 16, err_reg = 0x0008. Second start edge during DRAIN → err[1] set, batch completes normally.
- n_rst low during DRAIN → next cycle all outputs 0, status_reg = 0x00, err_reg = 0x0000, w_cnt = 0.

Source files
------------

// File: rtl/accel_ctrl_pkg.sv
// Shared types and bit positions for the inference sequencer and its
// register-facing status/error/control fields.
package accel_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_W,
      STREAM,
      DRAIN,
      ACT,
      OUT
   } state_t;

   localparam int ERR_BITS       = 5;
   localparam int ERR_START_NO_W = 0;
   localparam int ERR_START_BUSY = 1;
   localparam int ERR_PUSH_BUSY  = 2;
   localparam int ERR_W_OVF      = 3;
   localparam int ERR_TIMEOUT    = 4;

   localparam int STS_BUSY      = 0;
   localparam int STS_DONE      = 1;
   localparam int STS_W_READY   = 2;
   localparam int STS_OUT_VALID = 3;
   localparam int STS_ERR       = 4;

   localparam int CTRL_START   = 0;
   localparam int CTRL_CLR_ERR = 1;

endpackage

// File: rtl/wfifo_occ_counter.sv
// Saturating up/down occupancy counter; flags an increment attempted while full.
module wfifo_occ_counter #(
   parameter int DEPTH = 16,
   parameter int W     = $clog2(DEPTH + 1)
) (
   input  logic         clk,
   input  logic         n_rst,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] count,
   output logic         overflow
);

   localparam logic [W-1:0] MAX = W'(DEPTH);

   assign overflow = inc & ~dec & (count == MAX);

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         count <= '0;
      end else if (inc & ~dec) begin
         if (count != MAX) count <= count + 1'b1;
      end else if (dec & ~inc) begin
         if (count != '0) count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/accel_seq_ctrl.sv
// Batch sequencer: weight load, input stream, array drain, bias/activation,
// output hand-off, with weight occupancy tracking and sticky error reporting.
module accel_seq_ctrl
   import accel_ctrl_pkg::*;
#(
   parameter int ARRAY_DIM    = 8,
   parameter int WFIFO_DEPTH  = 16,
   parameter int DRAIN_CYCLES = 14,
   parameter int TIMEOUT      = 255
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic [7:0]  ctrl_reg,
   input  logic        wr_en_push,
   input  logic        is_weight,
   input  logic        handshake,
   input  logic        ififo_empty,
   output logic        wfifo_pop,
   output logic        w_load,
   output logic        ififo_pop,
   output logic        array_en,
   output logic        bias_act_en,
   output logic        out_valid,
   output logic [7:0]  status_reg,
   output logic [15:0] err_reg
);

   localparam int CW = $clog2(WFIFO_DEPTH + 1);
   localparam int BW = $clog2(ARRAY_DIM + 1);
   localparam int DW = $clog2(DRAIN_CYCLES + 1);
   localparam int SW = $clog2(TIMEOUT + 1);

   localparam logic [BW-1:0] LAST_BEAT  = BW'(ARRAY_DIM - 1);
   localparam logic [DW-1:0] LAST_DRAIN = DW'(DRAIN_CYCLES - 1);
   localparam logic [SW-1:0] LAST_STALL = SW'(TIMEOUT - 1);
   localparam logic [CW-1:0] W_NEEDED   = CW'(ARRAY_DIM);

   state_t                state, state_next;
   logic [BW-1:0]         beat_cnt, beat_next;
   logic [SW-1:0]         stall_cnt, stall_next;
   logic [DW-1:0]         drain_cnt, drain_next;
   logic                  done, done_next;
   logic [ERR_BITS-1:0]   err, err_set;
   logic                  start_prev;
   logic                  start_edge;
   logic                  w_push;
   logic                  w_ovf;
   logic                  w_ready;
   logic [CW-1:0]         w_cnt;
   logic                  ctrl_unused;

   assign ctrl_unused = ^ctrl_reg[7:2];
   assign start_edge  = ctrl_reg[CTRL_START] & ~start_prev;
   assign w_push      = wr_en_push & is_weight;
   assign w_ready     = (w_cnt >= W_NEEDED);

   wfifo_occ_counter #(
      .DEPTH (WFIFO_DEPTH),
      .W     (CW)
   ) u_wocc (
      .clk      (clk),
      .n_rst    (n_rst),
      .inc      (w_push),
      .dec      (wfifo_pop),
      .count    (w_cnt),
      .overflow (w_ovf)
   );

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state      <= IDLE;
         beat_cnt   <= '0;
         stall_cnt  <= '0;
         drain_cnt  <= '0;
         done       <= 1'b0;
         err        <= '0;
         start_prev <= 1'b0;
      end else begin
         state      <= state_next;
         beat_cnt   <= beat_next;
         stall_cnt  <= stall_next;
         drain_cnt  <= drain_next;
         done       <= done_next;
         err        <= (ctrl_reg[CTRL_CLR_ERR] ? '0 : err) | err_set;
         start_prev <= ctrl_reg[CTRL_START];
      end
   end

   always_comb begin
      state_next = state;
      beat_next  = beat_cnt;
      stall_next = stall_cnt;
      drain_next = drain_cnt;
      done_next  = done;
      err_set    = '0;

      case (state)
         IDLE: begin
            if (start_edge) begin
               if (w_ready) begin
                  state_next = LOAD_W;
                  done_next  = 1'b0;
                  beat_next  = '0;
               end else begin
                  err_set[ERR_START_NO_W] = 1'b1;
               end
            end
         end
         LOAD_W: begin
            if (beat_cnt == LAST_BEAT) begin
               state_next = STREAM;
               beat_next  = '0;
               stall_next = '0;
            end else begin
               beat_next = beat_cnt + 1'b1;
            end
         end
         STREAM: begin
            // A pop resets the starvation count; only consecutive empty cycles time out.
            if (!ififo_empty) begin
               stall_next = '0;
               if (beat_cnt == LAST_BEAT) begin
                  state_next = DRAIN;
                  drain_next = '0;
               end else begin
                  beat_next = beat_cnt + 1'b1;
               end
            end else if (stall_cnt == LAST_STALL) begin
               state_next           = IDLE;
               err_set[ERR_TIMEOUT] = 1'b1;
            end else begin
               stall_next = stall_cnt + 1'b1;
            end
         end
         DRAIN: begin
            if (drain_cnt == LAST_DRAIN) state_next = ACT;
            else                         drain_next = drain_cnt + 1'b1;
         end
         ACT: state_next = OUT;
         OUT: begin
            if (handshake) begin
               state_next = IDLE;
               done_next  = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase

      if (start_edge && state != IDLE)                  err_set[ERR_START_BUSY] = 1'b1;
      if (w_push && (state == LOAD_W || state == STREAM)) err_set[ERR_PUSH_BUSY] = 1'b1;
      if (w_ovf)                                         err_set[ERR_W_OVF]      = 1'b1;
   end

   assign wfifo_pop   = (state == LOAD_W);
   assign w_load      = (state == LOAD_W);
   assign ififo_pop   = (state == STREAM) & ~ififo_empty;
   assign array_en    = ififo_pop | (state == DRAIN);
   assign bias_act_en = (state == ACT);
   assign out_valid   = (state == OUT);

   always_comb begin
      status_reg                = '0;
      status_reg[STS_BUSY]      = (state != IDLE);
      status_reg[STS_DONE]      = done;
      status_reg[STS_W_READY]   = w_ready;
      status_reg[STS_OUT_VALID] = out_valid;
      status_reg[STS_ERR]       = |err;
   end

   assign err_reg = {{(16 - ERR_BITS){1'b0}}, err};

endmodule

// File: tb/tb_accel_seq_ctrl.sv
// Self-checking bench for accel_seq_ctrl: vector table for idle-time register
// behaviour, scoreboarded per-cycle output timelines for whole batches.
`timescale 1ns/1ps
module tb_accel_seq_ctrl;

   logic        clk;
   logic        n_rst;
   logic [7:0]  ctrl_reg;
   logic        wr_en_push;
   logic        is_weight;
   logic        handshake;
   logic        ififo_empty;
   logic        wfifo_pop;
   logic        w_load;
   logic        ififo_pop;
   logic        array_en;
   logic        bias_act_en;
   logic        out_valid;
   logic [7:0]  status_reg;
   logic [15:0] err_reg;

   int checks = 0;
   int errors = 0;
   logic [6:0] exp_q[$];

   typedef struct {
      logic       push;
      logic       weight;
      logic [7:0] ctrl;
      logic [7:0] exp_status;
      logic [15:0] exp_err;
   } vec_t;

   vec_t vecs[16];

   accel_seq_ctrl #(
      .TIMEOUT (4)
   ) dut (
      .clk         (clk),
      .n_rst       (n_rst),
      .ctrl_reg    (ctrl_reg),
      .wr_en_push  (wr_en_push),
      .is_weight   (is_weight),
      .handshake   (handshake),
      .ififo_empty (ififo_empty),
      .wfifo_pop   (wfifo_pop),
      .w_load      (w_load),
      .ififo_pop   (ififo_pop),
      .array_en    (array_en),
      .bias_act_en (bias_act_en),
      .out_valid   (out_valid),
      .status_reg  (status_reg),
      .err_reg     (err_reg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   function automatic logic [6:0] outs_now();
      return {status_reg[0], wfifo_pop, w_load, ififo_pop, array_en, bias_act_en, out_valid};
   endfunction

   // Expected {busy, wfifo_pop, w_load, ififo_pop, array_en, bias_act_en, out_valid}
   // for cycle t of a batch whose start edge is at t=0.
   function automatic logic [6:0] batch_outs(input int t, input int stall_at, input int stall_len,
                                             input int hs_t);
      int  s_end;
      int  act_t;
      logic busy, load, strm, stall, pop, drain, ae, ba, ov;
      s_end = 17 + stall_len;
      act_t = s_end + 14;
      busy  = (t >= 1) && (t <= hs_t);
      load  = (t >= 1) && (t <= 8);
      strm  = (t >= 9) && (t < s_end);
      stall = (t >= 9 + stall_at) && (t < 9 + stall_at + stall_len);
      pop   = strm && !stall;
      drain = (t >= s_end) && (t < act_t);
      ae    = pop || drain;
      ba    = (t == act_t);
      ov    = (t > act_t) && (t <= hs_t);
      return {busy, load, load, pop, ae, ba, ov};
   endfunction

   task automatic apply_stimulus(input vec_t v, input int idx);
      wr_en_push = v.push;
      is_weight  = v.weight;
      ctrl_reg   = v.ctrl;
      tick();
      check_output($sformatf("vec%0d status", idx), 32'(status_reg), 32'(v.exp_status));
      check_output($sformatf("vec%0d err", idx), 32'(err_reg), 32'(v.exp_err));
   endtask

   task automatic push_weights(input int n);
      for (int i = 0; i < n; i++) begin
         wr_en_push = 1'b1;
         is_weight  = 1'b1;
         tick();
      end
      wr_en_push = 1'b0;
      is_weight  = 1'b0;
   endtask

   task automatic run_batch(input int stall_at, input int stall_len, input int hs_off,
                            input int restart_t, input int push_t,
                            input logic [7:0] exp_sts, input logic [15:0] exp_err);
      int hs_t;
      int pops;
      logic [6:0] e;
      hs_t = 17 + stall_len + 15 + hs_off;
      pops = 0;
      for (int t = 0; t <= hs_t + 1; t++) begin
         ctrl_reg    = (t == 0 || t == restart_t) ? 8'h01 : 8'h00;
         wr_en_push  = (t == push_t);
         is_weight   = (t == push_t);
         ififo_empty = (t >= 9 + stall_at) && (t < 9 + stall_at + stall_len);
         handshake   = (t == hs_t);
         exp_q.push_back(batch_outs(t, stall_at, stall_len, hs_t));
         #1;
         e = exp_q.pop_front();
         check_output($sformatf("outs t=%0d", t), 32'(outs_now()), 32'(e));
         if (ififo_pop) pops++;
         if (t == hs_t + 1) begin
            check_output("batch end status", 32'(status_reg), 32'(exp_sts));
            check_output("batch end err", 32'(err_reg), 32'(exp_err));
         end
         tick();
      end
      ctrl_reg    = 8'h00;
      handshake   = 1'b0;
      wr_en_push  = 1'b0;
      is_weight   = 1'b0;
      ififo_empty = 1'b1;
      check_output("pop count", 32'(pops), 32'd8);
   endtask

   initial begin
      logic [6:0] e;

      vecs[0]  = '{1'b0, 1'b0, 8'h00, 8'h00, 16'h0000};
      vecs[1]  = '{1'b1, 1'b1, 8'h00, 8'h00, 16'h0000};
      vecs[2]  = '{1'b1, 1'b1, 8'h00, 8'h00, 16'h0000};
      vecs[3]  = '{1'b1, 1'b1, 8'h00, 8'h00, 16'h0000};
      vecs[4]  = '{1'b1, 1'b1, 8'h00, 8'h00, 16'h0000};
      vecs[5]  = '{1'b1, 1'b1, 8'h00, 8'h00, 16'h0000};
      vecs[6]  = '{1'b0, 1'b0, 8'h01, 8'h10, 16'h0001};
      vecs[7]  = '{1'b0, 1'b0, 8'h00, 8'h10, 16'h0001};
      vecs[8]  = '{1'b0, 1'b0, 8'h02, 8'h00, 16'h0000};
      vecs[9]  = '{1'b1, 1'b0, 8'h00, 8'h00, 16'h0000};
      vecs[10] = '{1'b0, 1'b0, 8'h03, 8'h10, 16'h0001};
      vecs[11] = '{1'b0, 1'b0, 8'h02, 8'h00, 16'h0000};
      vecs[12] = '{1'b1, 1'b1, 8'h00, 8'h00, 16'h0000};
      vecs[13] = '{1'b1, 1'b1, 8'h00, 8'h00, 16'h0000};
      vecs[14] = '{1'b1, 1'b1, 8'h00, 8'h04, 16'h0000};
      vecs[15] = '{1'b0, 1'b0, 8'h00, 8'h04, 16'h0000};

      n_rst       = 1'b0;
      ctrl_reg    = 8'h00;
      wr_en_push  = 1'b0;
      is_weight   = 1'b0;
      handshake   = 1'b0;
      ififo_empty = 1'b1;
      tick();
      tick();
      check_output("reset outs", 32'(outs_now()), 32'd0);
      check_output("reset status", 32'(status_reg), 32'h00);
      check_output("reset err", 32'(err_reg), 32'h0000);
      n_rst = 1'b1;

      for (int i = 0; i < 16; i++) apply_stimulus(vecs[i], i);

      // Nominal batch: handshake at cycle 35, idle with done at 36.
      run_batch(0, 0, 3, -1, -1, 8'h02, 16'h0000);

      // Three starved cycles mid-stream push ACT out by three.
      push_weights(8);
      check_output("reload status", 32'(status_reg), 32'h06);
      run_batch(3, 3, 0, -1, -1, 8'h02, 16'h0000);

      // Input FIFO stuck empty: timeout after four starved cycles.
      push_weights(8);
      for (int t = 0; t <= 13; t++) begin
         ctrl_reg    = (t == 0) ? 8'h01 : 8'h00;
         ififo_empty = 1'b1;
         exp_q.push_back({(t >= 1 && t <= 12), (t >= 1 && t <= 8), (t >= 1 && t <= 8), 4'b0000});
         #1;
         e = exp_q.pop_front();
         check_output($sformatf("timeout outs t=%0d", t), 32'(outs_now()), 32'(e));
         if (t == 13) begin
            check_output("timeout status", 32'(status_reg), 32'h10);
            check_output("timeout err", 32'(err_reg), 32'h0010);
         end
         tick();
      end
      ctrl_reg = 8'h02;
      tick();
      ctrl_reg = 8'h00;
      check_output("clear after timeout status", 32'(status_reg), 32'h00);
      check_output("clear after timeout err", 32'(err_reg), 32'h0000);

      // Saturation of the weight occupancy at the FIFO depth.
      push_weights(16);
      check_output("16 weights status", 32'(status_reg), 32'h04);
      check_output("16 weights err", 32'(err_reg), 32'h0000);
      push_weights(1);
      check_output("17th weight status", 32'(status_reg), 32'h14);
      check_output("17th weight err", 32'(err_reg), 32'h0008);
      ctrl_reg = 8'h02;
      tick();
      ctrl_reg = 8'h00;
      check_output("clear ovf err", 32'(err_reg), 32'h0000);

      // Re-start during DRAIN and a weight push during STREAM; batch still completes.
      run_batch(0, 0, 1, 19, 10, 8'h16, 16'h0006);
      ctrl_reg = 8'h02;
      tick();
      ctrl_reg = 8'h00;
      check_output("clear busy errs", 32'(err_reg), 32'h0000);

      // Occupancy 9 -> 1 after another batch; 6 more leaves 7, too few to start.
      run_batch(0, 0, 0, -1, -1, 8'h02, 16'h0000);
      push_weights(6);
      ctrl_reg = 8'h01;
      tick();
      ctrl_reg = 8'h00;
      check_output("7 weights start status", 32'(status_reg), 32'h12);
      check_output("7 weights start err", 32'(err_reg), 32'h0001);
      push_weights(1);
      ctrl_reg = 8'h02;
      tick();
      ctrl_reg = 8'h00;
      check_output("8 weights status", 32'(status_reg), 32'h06);

      // Reset asserted in DRAIN aborts the batch and clears everything.
      ififo_empty = 1'b0;
      for (int t = 0; t <= 20; t++) begin
         ctrl_reg = (t == 0) ? 8'h01 : 8'h00;
         if (t == 20) n_rst = 1'b0;
         #1;
         if (t == 18) check_output("drain array_en", 32'(array_en), 32'd1);
         tick();
      end
      check_output("mid-drain reset outs", 32'(outs_now()), 32'd0);
      check_output("mid-drain reset status", 32'(status_reg), 32'h00);
      check_output("mid-drain reset err", 32'(err_reg), 32'h0000);
      n_rst       = 1'b1;
      ififo_empty = 1'b1;
      push_weights(7);
      ctrl_reg = 8'h01;
      tick();
      ctrl_reg = 8'h00;
      check_output("post-reset occupancy start status", 32'(status_reg), 32'h10);
      check_output("post-reset occupancy start err", 32'(err_reg), 32'h0001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
